// File: rtl/pc_sequencer_pkg.sv
// Shared core constants: RV32 opcodes and branch funct3 codes used by fetch sequencing,
// plus the sequencer state type.
package cpu_pkg;

   localparam logic [6:0]  OP_BRANCH    = 7'h63;
   localparam logic [6:0]  OP_JAL       = 7'h6f;
   localparam logic [6:0]  OP_JALR      = 7'h67;
   localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SEQ_RUN,
      SEQ_FLUSH,
      SEQ_HALT
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/EX signal bundle between the PC sequencer (master) and the rest of the core
// (instruction memory, control decoder, ALU, register file).
interface pc_sequencer_if #(
   parameter int unsigned AW = 12
);

   logic [31:0]   instr_EX;
   logic [31:0]   alu_R_EX;
   logic [31:0]   rs1_EX;
   logic [AW-1:0] pc_FETCH;
   logic [AW-1:0] pc_EX;
   logic [31:0]   link_EX;
   logic          stall_EX;
   logic          halted;

   modport master (
      input  instr_EX, alu_R_EX, rs1_EX,
      output pc_FETCH, pc_EX, link_EX, stall_EX, halted
   );

   modport slave (
      output instr_EX, alu_R_EX, rs1_EX,
      input  pc_FETCH, pc_EX, link_EX, stall_EX, halted
   );

endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational branch/jump resolution for the instruction in EX: decides whether fetch
// must be redirected and computes the word-addressed target (wraps modulo 2^AW).
module pc_target_calc
   import cpu_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic [31:0]   instr_EX,
   input  logic [31:0]   alu_R_EX,
   input  logic [31:0]   rs1_EX,
   input  logic [AW-1:0] pc_EX,
   output logic          redirect,
   output logic [AW-1:0] target
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic [31:0] imm_i;
   logic [31:0] jalr_sum;

   always_comb begin
      opcode   = instr_EX[6:0];
      funct3   = instr_EX[14:12];
      imm_b    = {{20{instr_EX[31]}}, instr_EX[7], instr_EX[30:25], instr_EX[11:8], 1'b0};
      imm_j    = {{12{instr_EX[31]}}, instr_EX[19:12], instr_EX[20], instr_EX[30:21], 1'b0};
      imm_i    = {{20{instr_EX[31]}}, instr_EX[31:20]};
      jalr_sum = rs1_EX + imm_i;

      redirect = 1'b0;
      // Byte offsets become word offsets by arithmetic shift; truncation gives the 2^AW wrap.
      target   = pc_EX + AW'($signed(imm_b) >>> 2);

      case (opcode)
         OP_BRANCH: begin
            case (funct3)
               F3_BEQ:  redirect = (alu_R_EX == '0);
               F3_BNE:  redirect = (alu_R_EX != '0);
               F3_BLT,
               F3_BLTU: redirect = alu_R_EX[0];
               F3_BGE,
               F3_BGEU: redirect = ~alu_R_EX[0];
               default: redirect = 1'b0;
            endcase
         end
         OP_JAL: begin
            redirect = 1'b1;
            target   = pc_EX + AW'($signed(imm_j) >>> 2);
         end
         OP_JALR: begin
            redirect = 1'b1;
            target   = AW'(jalr_sum >> 2);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the 2-stage FETCH/EX core: sequential fetch, one-bubble
// redirect on taken branches/jumps, and halt on EBREAK until reset.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned AW       = 12,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
   pc_sequencer_if.master bus
);

   seq_state_t    state_q, state_d;
   logic [AW-1:0] pc_fetch_q, pc_fetch_d;
   logic [AW-1:0] pc_ex_q, pc_ex_d;
   logic [AW-1:0] pc_ex_inc;
   logic          redirect;
   logic [AW-1:0] target;

   pc_target_calc #(
      .AW(AW)
   ) u_target_calc (
      .instr_EX (bus.instr_EX),
      .alu_R_EX (bus.alu_R_EX),
      .rs1_EX   (bus.rs1_EX),
      .pc_EX    (pc_ex_q),
      .redirect (redirect),
      .target   (target)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SEQ_FLUSH;
         pc_fetch_q <= AW'(RESET_PC);
         pc_ex_q    <= AW'(RESET_PC);
      end else begin
         state_q    <= state_d;
         pc_fetch_q <= pc_fetch_d;
         pc_ex_q    <= pc_ex_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_fetch_d = pc_fetch_q + 1'b1;
      pc_ex_d    = pc_fetch_q;
      case (state_q)
         SEQ_RUN: begin
            if (bus.instr_EX == INSTR_EBREAK) begin
               state_d    = SEQ_HALT;
               pc_fetch_d = pc_fetch_q;
            end else if (redirect) begin
               state_d    = SEQ_FLUSH;
               pc_fetch_d = target;
            end
         end
         SEQ_FLUSH: begin
            state_d = SEQ_RUN;
         end
         SEQ_HALT: begin
            pc_fetch_d = pc_fetch_q;
            pc_ex_d    = pc_ex_q;
         end
         default: begin
            state_d = SEQ_FLUSH;
         end
      endcase
   end

   always_comb begin
      pc_ex_inc    = pc_ex_q + 1'b1;
      bus.pc_FETCH = pc_fetch_q;
      bus.pc_EX    = pc_ex_q;
      bus.link_EX  = 32'({pc_ex_inc, 2'b00});
      bus.stall_EX = (state_q != SEQ_RUN);
      bus.halted   = (state_q == SEQ_HALT);
   end

endmodule
